mif_wr: RTL and testbench

Memory-interface write engine sitting directly downstream of the output buffer controller. Pops one buffered write request (address, byte mask, data) at a time, issues it to the memory port over a req/ack handshake, and performs a read-modify-write when the byte mask is partial. Keeps a completed-write counter for debug and status.

---
 rtl/mif_wr.sv | 137 +++++++++++++
 tb/tb_mif_wr.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mif_wr.sv
// mif_wr: pops buffered write requests and issues them to the memory port,
// doing a read-modify-write whenever the byte mask is partial.
module mif_wr #(
    parameter int unsigned wAddrWidth = 28,
    parameter int unsigned wDataWidth = 64,
    parameter int unsigned wMaskWidth = 8,
    parameter int unsigned wCntWidth  = 16
) (
    input  logic                             clk_bus,
    input  logic                             rst_bus,
    input  logic                             obc2mem_w_vld,
    input  logic [wAddrWidth-1:0]            obc2mem_w_addr,
    input  logic [wMaskWidth+wDataWidth-1:0] obc2mem_w_data,
    output logic                             mem2obc_en,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [wAddrWidth-1:0]            mem_addr,
    output logic [wDataWidth-1:0]            mem_wdata,
    input  logic [wDataWidth-1:0]            mem_rdata,
    input  logic                             mem_ack,
    output logic                             mif_busy,
    output logic [wCntWidth-1:0]             mif_wr_cnt
);

    localparam int unsigned EntryWidth = wMaskWidth + wDataWidth;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [wMaskWidth-1:0]   mask_q;
    logic [wDataWidth-1:0]   data_q;
    logic [wMaskWidth-1:0]   in_mask;
    logic [wDataWidth-1:0]   in_data;
    logic [wDataWidth-1:0]   merged;

    assign in_mask = obc2mem_w_data[EntryWidth-1:wDataWidth];
    assign in_data = obc2mem_w_data[wDataWidth-1:0];

    // State register
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded strobes; the pop strobe is gated by reset
    always_comb begin
        state_nxt  = state;
        mem2obc_en = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mif_busy   = 1'b0;
        case (state)
            IDLE: begin
                mem2obc_en = obc2mem_w_vld & ~rst_bus;
                if (obc2mem_w_vld) begin
                    if (&in_mask) begin
                        state_nxt = WR;
                    end else if (|in_mask) begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                mem_req  = 1'b1;
                mif_busy = 1'b1;
                if (mem_ack) begin
                    state_nxt = WR;
                end
            end
            WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mif_busy = 1'b1;
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte merge of captured data over the word returned by the read
    always_comb begin
        merged = mem_rdata;
        for (int unsigned i = 0; i < wMaskWidth; i++) begin
            if (mask_q[i]) begin
                merged[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end

    // Holding registers, memory address/data and completed-write counter
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            mif_wr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (obc2mem_w_vld) begin
                        mem_addr <= obc2mem_w_addr;
                        mask_q   <= in_mask;
                        data_q   <= in_data;
                        if (&in_mask) begin
                            mem_wdata <= in_data;
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        mem_wdata <= merged;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mif_wr_cnt <= mif_wr_cnt + wCntWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mif_wr.sv
// tb_mif_wr: buffer model, memory responder and write scoreboard around mif_wr.
module tb_mif_wr;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 64;
    localparam int unsigned MW = 8;
    localparam int unsigned CW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
    } entry_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic             clk_bus = 1'b0;
    logic             rst_bus = 1'b1;
    logic             obc2mem_w_vld = 1'b0;
    logic [AW-1:0]    obc2mem_w_addr = '0;
    logic [MW+DW-1:0] obc2mem_w_data = '0;
    logic             mem2obc_en;
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic             mem_ack = 1'b0;
    logic             mif_busy;
    logic [CW-1:0]    mif_wr_cnt;

    int checks = 0;
    int errors = 0;

    entry_t        fifo[$];
    wr_t           exp_q[$];
    int            pop_cycles[$];
    logic [DW-1:0] mem_model[logic [AW-1:0]];
    logic [CW-1:0] exp_cnt = '0;
    int            rd_delay = 0;
    int            wr_delay = 0;
    int            wcnt = 0;
    int            cyc = 0;
    logic          pop_pend = 1'b0;
    entry_t        e;
    wr_t           w;
    wr_t           ex;
    logic [DW-1:0] old;

    mif_wr #(
        .wAddrWidth(AW),
        .wDataWidth(DW),
        .wMaskWidth(MW),
        .wCntWidth (CW)
    ) dut (
        .clk_bus       (clk_bus),
        .rst_bus       (rst_bus),
        .obc2mem_w_vld (obc2mem_w_vld),
        .obc2mem_w_addr(obc2mem_w_addr),
        .obc2mem_w_data(obc2mem_w_data),
        .mem2obc_en    (mem2obc_en),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .mif_busy      (mif_busy),
        .mif_wr_cnt    (mif_wr_cnt)
    );

    always #5 clk_bus = ~clk_bus;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 64'hA5A5_0000_0000_0000 ^ DW'(a);
    endfunction

    // Buffer model: pop on strobe, push expected write, present new head
    always @(posedge clk_bus) begin
        cyc++;
        if (pop_pend && !rst_bus && fifo.size() != 0) begin
            e = fifo.pop_front();
            pop_cycles.push_back(cyc);
            if (e.mask != '0) begin
                old = mem_rd(e.addr);
                for (int i = 0; i < int'(MW); i++)
                    w.data[8*i +: 8] = e.mask[i] ? e.data[8*i +: 8] : old[8*i +: 8];
                w.addr = e.addr;
                exp_q.push_back(w);
            end
        end
        #1;
        if (fifo.size() != 0) begin
            obc2mem_w_vld  = 1'b1;
            obc2mem_w_addr = fifo[0].addr;
            obc2mem_w_data = {fifo[0].mask, fifo[0].data};
        end else begin
            obc2mem_w_vld = 1'b0;
        end
    end

    // Memory responder and write scoreboard
    always @(negedge clk_bus) begin
        pop_pend = mem2obc_en;
        if (mem_req) begin
            if (wcnt >= (mem_we ? wr_delay : rd_delay)) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (!mem_we) begin
                    mem_rdata = mem_rd(mem_addr);
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_write addr %h data %h", mem_addr, mem_wdata);
                    end else begin
                        ex = exp_q.pop_front();
                        if (mem_addr !== ex.addr || mem_wdata !== ex.data) begin
                            errors++;
                            $display("FAIL sb_write got %h/%h want %h/%h", mem_addr, mem_wdata, ex.addr, ex.data);
                        end
                    end
                    mem_model[mem_addr] = mem_wdata;
                    exp_cnt = exp_cnt + CW'(1);
                end
            end else begin
                mem_ack = 1'b0;
                mem_rdata = {$urandom, $urandom};
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Runs until the buffer is empty and the engine idle, gathering activity counts
    task automatic run_until_idle(input int limit, output int pops, output int busy,
                                  output int reqs, output int unstable, output bit timeout);
        logic          hold = 1'b0;
        logic          pwe = 1'b0;
        logic [AW-1:0] pa = '0;
        logic [DW-1:0] pd = '0;
        pops = 0; busy = 0; reqs = 0; unstable = 0; timeout = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_bus);
            #1;
            if (mem2obc_en) pops++;
            if (mif_busy) busy++;
            if (mem_req) reqs++;
            if (hold && mem_req && (mem_we !== pwe || mem_addr !== pa || mem_wdata !== pd))
                unstable++;
            hold = mem_req && !mem_ack;
            pwe = mem_we; pa = mem_addr; pd = mem_wdata;
            if (fifo.size() == 0 && !mif_busy && !mem2obc_en) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        entry_t t;
        repeat (2) @(posedge clk_bus);
        t.addr = 28'h0000ABC; t.mask = 8'hFF; t.data = 64'hDEAD_BEEF_0000_0001;
        fifo.push_back(t);
        @(negedge clk_bus); #1;
        checks++;
        if (obc2mem_w_vld !== 1'b1 || mem2obc_en !== 1'b0) begin
            errors++; $display("FAIL reset_pop vld %b en %b want vld 1 en 0", obc2mem_w_vld, mem2obc_en);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mif_busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl req %b we %b busy %b want 000", mem_req, mem_we, mif_busy);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || mif_wr_cnt !== '0) begin
            errors++; $display("FAIL reset_regs addr %h wdata %h cnt %0d want 0", mem_addr, mem_wdata, mif_wr_cnt);
        end
        fifo.delete();
        @(posedge clk_bus); #2;
        rst_bus = 1'b0;
    endtask

    task automatic test_full();
        entry_t t;
        int pops, busy, reqs, unst;
        bit to;
        rd_delay = 0; wr_delay = 0;
        t.addr = 28'h0000123; t.mask = 8'hFF; t.data = 64'h1122334455667788;
        fifo.push_back(t);
        run_until_idle(50, pops, busy, reqs, unst, to);
        checks++;
        if (to || pops != 1 || busy != 1 || reqs != 1) begin
            errors++; $display("FAIL full_timing to %0d pops %0d busy %0d reqs %0d want 0 1 1 1", to, pops, busy, reqs);
        end
        checks++;
        if (mem_model[28'h0000123] !== 64'h1122334455667788) begin
            errors++; $display("FAIL full_data got %h want 1122334455667788", mem_model[28'h0000123]);
        end
        checks++;
        if (mif_wr_cnt !== CW'(1) || exp_q.size() != 0) begin
            errors++; $display("FAIL full_cnt got %0d pending %0d want 1 0", mif_wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_rmw();
        entry_t t;
        int pops, busy, reqs, unst;
        bit to;
        mem_model[28'h10] = 64'hAAAAAAAAAAAAAAAA;
        t.addr = 28'h10; t.mask = 8'h0F; t.data = 64'h1111111111111111;
        fifo.push_back(t);
        run_until_idle(50, pops, busy, reqs, unst, to);
        checks++;
        if (to || pops != 1 || busy != 2 || reqs != 2) begin
            errors++; $display("FAIL rmw_timing to %0d pops %0d busy %0d reqs %0d want 0 1 2 2", to, pops, busy, reqs);
        end
        checks++;
        if (mem_model[28'h10] !== 64'hAAAAAAAA11111111) begin
            errors++; $display("FAIL rmw_data got %h want aaaaaaaa11111111", mem_model[28'h10]);
        end
        checks++;
        if (mif_wr_cnt !== CW'(2) || exp_q.size() != 0) begin
            errors++; $display("FAIL rmw_cnt got %0d pending %0d want 2 0", mif_wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_zero_mask();
        entry_t t;
        int pops, busy, reqs, unst;
        bit to;
        t.addr = 28'h55; t.mask = 8'h00; t.data = 64'hFFFF_FFFF_FFFF_FFFF;
        fifo.push_back(t);
        run_until_idle(50, pops, busy, reqs, unst, to);
        checks++;
        if (to || pops != 1 || busy != 0 || reqs != 0) begin
            errors++; $display("FAIL zero_timing to %0d pops %0d busy %0d reqs %0d want 0 1 0 0", to, pops, busy, reqs);
        end
        checks++;
        if (mif_wr_cnt !== CW'(2) || mem_model.exists(28'h55)) begin
            errors++; $display("FAIL zero_cnt got %0d written %0d want 2 0", mif_wr_cnt, mem_model.exists(28'h55));
        end
    endtask

    task automatic test_backpressure();
        entry_t t;
        int pops, busy, reqs, unst;
        bit to;
        rd_delay = 5; wr_delay = 3;
        t.addr = 28'h40; t.mask = 8'h3C; t.data = 64'h0123_4567_89AB_CDEF;
        fifo.push_back(t);
        t.addr = 28'h41; t.mask = 8'hFF;
        fifo.push_back(t);
        run_until_idle(100, pops, busy, reqs, unst, to);
        checks++;
        if (to || pops != 2 || busy != 14 || reqs != 14) begin
            errors++; $display("FAIL bp_timing to %0d pops %0d busy %0d reqs %0d want 0 2 14 14", to, pops, busy, reqs);
        end
        checks++;
        if (unst != 0) begin
            errors++; $display("FAIL bp_stable got %0d changes want 0", unst);
        end
        checks++;
        if (pop_cycles.size() < 2 || pop_cycles[pop_cycles.size()-1] - pop_cycles[pop_cycles.size()-2] != 11) begin
            errors++; $display("FAIL bp_pop_gap pops %0d want spacing 11", pop_cycles.size());
        end
        checks++;
        if (mif_wr_cnt !== CW'(4) || exp_q.size() != 0) begin
            errors++; $display("FAIL bp_cnt got %0d pending %0d want 4 0", mif_wr_cnt, exp_q.size());
        end
        rd_delay = 0; wr_delay = 0;
    endtask

    task automatic test_back_to_back();
        entry_t t;
        int pops, busy, reqs, unst, bad;
        bit to;
        for (int i = 0; i < 11; i++) begin
            t.addr = AW'(32'h200 + i); t.mask = 8'hFF; t.data = {$urandom, $urandom};
            fifo.push_back(t);
        end
        run_until_idle(200, pops, busy, reqs, unst, to);
        checks++;
        if (to || mif_wr_cnt !== 4'hF) begin
            errors++; $display("FAIL b2b_fill to %0d cnt %0d want 0 15", to, mif_wr_cnt);
        end
        pop_cycles.delete();
        for (int i = 0; i < 4; i++) begin
            t.addr = AW'(32'h300 + i); t.mask = 8'hFF; t.data = {$urandom, $urandom};
            fifo.push_back(t);
        end
        run_until_idle(100, pops, busy, reqs, unst, to);
        bad = 0;
        for (int i = 1; i < pop_cycles.size(); i++)
            if (pop_cycles[i] - pop_cycles[i-1] != 2) bad++;
        checks++;
        if (to || pop_cycles.size() != 4 || bad != 0) begin
            errors++; $display("FAIL b2b_spacing to %0d pops %0d bad_gaps %0d want 0 4 0", to, pop_cycles.size(), bad);
        end
        checks++;
        if (mif_wr_cnt !== CW'(3) || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_wrap got %0d pending %0d want 3 0", mif_wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_midop();
        entry_t t;
        bit seen = 1'b0;
        wr_delay = 30;
        t.addr = 28'h77; t.mask = 8'hFF; t.data = 64'h7777_0000_7777_0000;
        fifo.push_back(t);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_bus); #1;
            if (mem_req) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL midrst_req req %b want 1", mem_req);
        end
        @(posedge clk_bus); #2;
        rst_bus = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mif_busy !== 1'b0 || mem2obc_en !== 1'b0 || mif_wr_cnt !== '0) begin
            errors++; $display("FAIL midrst_ctrl req %b busy %b en %b cnt %0d want 0", mem_req, mif_busy, mem2obc_en, mif_wr_cnt);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL midrst_regs addr %h wdata %h we %b want 0", mem_addr, mem_wdata, mem_we);
        end
        exp_q.delete();
        exp_cnt = '0;
        wr_delay = 0;
        @(posedge clk_bus); #2;
        rst_bus = 1'b0;
        repeat (2) @(posedge clk_bus);
    endtask

    initial begin
        test_reset();
        test_full();
        test_rmw();
        test_zero_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        checks++;
        if (mif_wr_cnt !== exp_cnt) begin
            errors++; $display("FAIL final_cnt got %0d want %0d", mif_wr_cnt, exp_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
